sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//   Parametrised single-clock FIFO for DMA read/write data buffering between the AXI4-Lite
//   master engine and the channel datapath. Generalises the fixed 16x32 FIFO: configurable
//   width/depth, almost-full/almost-empty thresholds, occupancy count, standard or
//   first-word-fall-through read mode, full-with-read write acceptance, flush, sticky error flags.
// PARAMETERS
//   DATA_WIDTH     32   width of write_data/read_data
//   ADDR_WIDTH     4    log2(depth); DEPTH = 2**ADDR_WIDTH (legal 2..10)
//   AFULL_THRESH   12   FIFO_AFULL asserted when count >= this (1..DEPTH)
//   AEMPTY_THRESH  4    FIFO_AEMPTY asserted when count <= this (0..DEPTH-1)
//   FWFT           0    0 = standard registered read; 1 = first-word-fall-through
// PORTS
//   clk          in   1             rising-edge clock
//   reset        in   1             synchronous, active-high reset
//   flush        in   1             synchronous discard of all contents
//   err_clr      in   1             clears OVERFLOW/UNDERFLOW
//   FIFO_WR_EN   in   1             write request
//   write_data   in   DATA_WIDTH    write data
//   FIFO_RD_EN   in   1             read request / pop
//   read_data    out  DATA_WIDTH    read data
//   read_valid   out  1             read_data holds a valid popped (std) / head (FWFT) word
//   FIFO_FULL    out  1             count == DEPTH
//   FIFO_EMPTY   out  1             count == 0
//   FIFO_AFULL   out  1             count >= AFULL_THRESH
//   FIFO_AEMPTY  out  1             count <= AEMPTY_THRESH
//   FIFO_COUNT   out  ADDR_WIDTH+1  occupancy 0..DEPTH
//   OVERFLOW     out  1             sticky: write rejected
//   UNDERFLOW    out  1             sticky: read rejected
// BEHAVIOUR
//   - Pointers wr_ptr/rd_ptr are ADDR_WIDTH+1 bits with wrap MSB. count = wr_ptr - rd_ptr
//     (mod 2**(ADDR_WIDTH+1)). FULL/EMPTY/AFULL/AEMPTY/COUNT are combinational from the
//     registered pointers, so they reflect an accepted op one cycle later.
//   - Reset (priority 1): pointers = 0, read_data = 0, read_valid = 0, OVERFLOW = UNDERFLOW = 0.
//     Memory contents are not reset. Outputs after reset: EMPTY=1, AEMPTY=1, FULL=0, AFULL=0, COUNT=0.
//   - Flush (priority 2): pointers = 0, read_valid = 0; read_data holds; the same-cycle
//     write/read is discarded and does not set the error flags. Error flags are unaffected
//     unless err_clr is also high.
//   - rd_acc = FIFO_RD_EN & !FIFO_EMPTY.
//   - wr_acc = FIFO_WR_EN & (!FIFO_FULL | rd_acc). A write while full is accepted when a
//     read is accepted in the same cycle; count is unchanged.
//   - Write when empty plus read: the read is rejected (UNDERFLOW sets) and the write is accepted.
//   - Accepted write: mem[wr_ptr[ADDR_WIDTH-1:0]] <= write_data; wr_ptr++.
//   - Accepted read: rd_ptr++.
//   - Standard mode (FWFT=0):
//     - On rd_acc, read_data <= head word and read_valid <= 1 for the next cycle.
//     - Otherwise read_data holds and read_valid <= 0. Latency is 1 cycle from RD_EN.
//   - FWFT mode (FWFT=1):
//     - read_data = mem[rd_addr] combinationally; read_valid = !FIFO_EMPTY.
//     - FIFO_RD_EN acknowledges the current head. A word written to an empty FIFO is visible
//       one cycle after its write.
//   - OVERFLOW sets on FIFO_WR_EN & !wr_acc. UNDERFLOW sets on FIFO_RD_EN & FIFO_EMPTY.
//     Both hold until err_clr or reset. If err_clr and a new error occur in the same cycle,
//     the set wins.
//   - Pointer wrap: the low bits roll DEPTH-1 -> 0 and the MSB toggles. FULL/EMPTY stay
//     correct across any number of wraps.
// TESTING
//   1 Reset, then DEPTH=16 writes of 0x100+i -> FULL=1, AFULL=1, COUNT=16. A 17th write
//     -> OVERFLOW=1, memory unchanged.
//   2 Drain 16 reads (std mode) -> read_data = 0x100..0x10F, each one cycle after RD_EN.
//     A 17th read -> UNDERFLOW=1 and read_data holds 0x10F.
//   3 When full, assert WR_EN+RD_EN with 0xAAAA -> COUNT stays 16, no OVERFLOW, 0xAAAA read last.
//   4 When empty, assert WR_EN+RD_EN -> COUNT=1, UNDERFLOW=1, read_valid=0.
//   5 40 interleaved ops crossing 2 pointer wraps -> data order is preserved; AFULL toggles at 12,
//     AEMPTY at 4. flush mid-stream -> COUNT=0 next cycle, errors kept. err_clr -> errors cleared.
//   6 With FWFT=1, write 0x55 to empty -> read_valid=1, read_data=0x55 next cycle with no RD_EN.
//     RD_EN -> EMPTY.

Source files
------------

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_param
//  Description : Parametrised single-clock FIFO for DMA data buffering.
//                Configurable width/depth, almost-full/almost-empty levels,
//                occupancy count, standard or first-word-fall-through read
//                mode, write-while-full acceptance when a read is accepted
//                in the same cycle, synchronous flush and sticky error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 4,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  err_clr,
    input  logic                  FIFO_WR_EN,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  FIFO_RD_EN,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  read_valid,
    output logic                  FIFO_FULL,
    output logic                  FIFO_EMPTY,
    output logic                  FIFO_AFULL,
    output logic                  FIFO_AEMPTY,
    output logic [ADDR_WIDTH:0]   FIFO_COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int                c_DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_DEPTH_CNT  = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] c_PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] c_AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

    // Storage and pointers (extra MSB distinguishes full from empty)
    logic [DATA_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_mem_we;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Status is derived purely from the registered pointers
    assign w_count   = r_wr_ptr - r_rd_ptr;
    assign w_full    = (w_count == c_DEPTH_CNT);
    assign w_empty   = (w_count == '0);
    assign w_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

    // A read frees a slot in the same cycle, so a write to a full FIFO is
    // allowed alongside an accepted read.
    assign w_rd_acc  = FIFO_RD_EN & ~w_empty;
    assign w_wr_acc  = FIFO_WR_EN & (~w_full | w_rd_acc);
    assign w_mem_we  = w_wr_acc & ~flush & ~reset;
    assign w_ovf_set = FIFO_WR_EN & ~w_wr_acc;
    assign w_udf_set = FIFO_RD_EN & w_empty;

    assign FIFO_COUNT  = w_count;
    assign FIFO_FULL   = w_full;
    assign FIFO_EMPTY  = w_empty;
    assign FIFO_AFULL  = (w_count >= c_AFULL_LVL);
    assign FIFO_AEMPTY = (w_count <= c_AEMPTY_LVL);
    assign OVERFLOW    = r_overflow;
    assign UNDERFLOW   = r_underflow;

    // Memory write port (contents are intentionally not reset)
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_addr] <= write_data;
        end
    end

    // Pointer update; flush discards any same-cycle read/write
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (flush) begin
            if (err_clr) begin
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented directly; valid whenever not empty
            assign read_data  = r_mem[w_rd_addr];
            assign read_valid = ~w_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_read_data;
            logic                  r_read_valid;

            // Registered read port: popped word appears one cycle after RD_EN
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_read_data  <= '0;
                    r_read_valid <= 1'b0;
                end else if (flush) begin
                    r_read_valid <= 1'b0;
                end else begin
                    r_read_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_read_data <= r_mem[w_rd_addr];
                    end
                end
            end

            assign read_data  = r_read_data;
            assign read_valid = r_read_valid;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_param
//  Description : Self-checking bench for sync_fifo_param (standard and FWFT
//                instances). Expected read words are queued at stimulus time
//                and popped by an independent read-side monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        err_clr;
    logic        wr_en;
    logic [31:0] wdata;
    logic        rd_en;
    logic [31:0] rdata;
    logic        rvalid;
    logic        full, empty, afull, aempty, ovf, udf;
    logic [4:0]  count;

    logic        f_flush, f_err_clr, f_wr, f_rd;
    logic [31:0] f_wdata;
    logic [31:0] f_rdata;
    logic        f_rvalid;
    logic        f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0]  f_count;

    int          n_checks = 0;
    int          n_err    = 0;
    logic [31:0] exp_q [$];
    logic [31:0] mdl   [$];
    logic [31:0] mon_e;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(0)
    ) u_std (
        .clk(clk), .reset(reset), .flush(flush), .err_clr(err_clr),
        .FIFO_WR_EN(wr_en), .write_data(wdata), .FIFO_RD_EN(rd_en),
        .read_data(rdata), .read_valid(rvalid),
        .FIFO_FULL(full), .FIFO_EMPTY(empty), .FIFO_AFULL(afull), .FIFO_AEMPTY(aempty),
        .FIFO_COUNT(count), .OVERFLOW(ovf), .UNDERFLOW(udf)
    );

    sync_fifo_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(4), .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset(reset), .flush(f_flush), .err_clr(f_err_clr),
        .FIFO_WR_EN(f_wr), .write_data(f_wdata), .FIFO_RD_EN(f_rd),
        .read_data(f_rdata), .read_valid(f_rvalid),
        .FIFO_FULL(f_full), .FIFO_EMPTY(f_empty), .FIFO_AFULL(f_afull), .FIFO_AEMPTY(f_aempty),
        .FIFO_COUNT(f_count), .OVERFLOW(f_ovf), .UNDERFLOW(f_udf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One standard-instance cycle; expected read words are queued here
    task automatic op(input bit wr, input bit rd, input logic [31:0] d, input bit fl = 1'b0);
        bit racc;
        bit wacc;
        racc = rd && (mdl.size() > 0);
        wacc = wr && ((mdl.size() < 16) || racc);
        if (fl) begin
            mdl.delete();
        end else begin
            if (racc) exp_q.push_back(mdl.pop_front());
            if (wacc) mdl.push_back(d);
        end
        wr_en = wr; rd_en = rd; wdata = d; flush = fl;
        cyc();
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("errclr_ovf", ovf, 0);
        check("errclr_udf", udf, 0);
    endtask

    // Read-side monitor: every valid read word must match the next queued word
    always @(negedge clk) begin
        if (!reset && rvalid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: actual=0x%0h required=none", rdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (rdata !== mon_e) begin
                    n_err++;
                    $display("FAIL rd_data: actual=0x%0h required=0x%0h", rdata, mon_e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; err_clr = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        f_flush = 1'b0; f_err_clr = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_wdata = '0;
        cyc(); cyc();
        reset = 1'b0;

        // 1: reset state, fill, overflow
        check("rst_empty",  empty,  1);
        check("rst_aempty", aempty, 1);
        check("rst_full",   full,   0);
        check("rst_afull",  afull,  0);
        check("rst_count",  count,  0);
        check("rst_ovf",    ovf,    0);
        check("rst_udf",    udf,    0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata",  rdata,  0);
        for (int i = 0; i < 16; i++) begin
            op(1'b1, 1'b0, 32'h100 + i);
            if (i == 10) check("afull_at11", afull, 0);
            if (i == 11) check("afull_at12", afull, 1);
        end
        check("fill_full",  full,  1);
        check("fill_afull", afull, 1);
        check("fill_count", count, 16);
        op(1'b1, 1'b0, 32'hDEAD);
        check("ovf_set",   ovf,   1);
        check("ovf_count", count, 16);

        // 2: drain, latency, underflow
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 32'h0);
            if (i == 0) begin
                check("lat_rvalid", rvalid, 1);
                check("lat_rdata",  rdata,  32'h100);
            end
            if (i == 10) check("aempty_at5", aempty, 0);
            if (i == 11) check("aempty_at4", aempty, 1);
        end
        check("drain_empty", empty, 1);
        op(1'b0, 1'b1, 32'h0);
        check("udf_set",     udf,    1);
        check("udf_rvalid",  rvalid, 0);
        check("udf_hold",    rdata,  32'h10F);
        clear_errors();

        // 3: write while full with simultaneous read
        for (int i = 0; i < 16; i++) op(1'b1, 1'b0, 32'h200 + i);
        op(1'b1, 1'b1, 32'hAAAA);
        check("wfull_count", count, 16);
        check("wfull_ovf",   ovf,   0);
        for (int i = 0; i < 16; i++) op(1'b0, 1'b1, 32'h0);
        check("wfull_last",  rdata, 32'hAAAA);
        check("wfull_empty", empty, 1);

        // 4: write+read when empty
        op(1'b1, 1'b1, 32'h77);
        check("we_count",  count,  1);
        check("we_udf",    udf,    1);
        check("we_rvalid", rvalid, 0);
        op(1'b0, 1'b1, 32'h0);

        // 5: interleaved traffic across pointer wraps, flush, err_clr
        for (int i = 0; i < 40; i++) begin
            op(1'b1, (i >= 14), 32'h300 + i);
            if (i == 10) check("il_afull_11", afull, 0);
            if (i == 11) check("il_afull_12", afull, 1);
        end
        check("il_count", count, 14);
        for (int i = 0; i < 10; i++) begin
            op(1'b0, 1'b1, 32'h0);
            if (i == 8) check("il_aempty_5", aempty, 0);
            if (i == 9) check("il_aempty_4", aempty, 1);
        end
        op(1'b1, 1'b1, 32'hBAD, 1'b1);
        check("fl_count",  count,  0);
        check("fl_empty",  empty,  1);
        check("fl_rvalid", rvalid, 0);
        check("fl_udf",    udf,    1);
        check("fl_ovf",    ovf,    0);
        clear_errors();
        op(1'b1, 1'b0, 32'h400);
        op(1'b0, 1'b1, 32'h0);
        check("postfl_data", rdata, 32'h400);

        // 6: first-word-fall-through instance
        check("f_rst_empty", f_empty,  1);
        check("f_rst_valid", f_rvalid, 0);
        f_wr = 1'b1; f_wdata = 32'h55;
        cyc();
        f_wr = 1'b0;
        check("f_valid", f_rvalid, 1);
        check("f_data",  f_rdata,  32'h55);
        cyc();
        check("f_hold",  f_rdata,  32'h55);
        f_rd = 1'b1;
        cyc();
        f_rd = 1'b0;
        check("f_pop_empty", f_empty,  1);
        check("f_pop_valid", f_rvalid, 0);
        f_wr = 1'b1; f_wdata = 32'h66;
        cyc();
        f_wdata = 32'h77;
        cyc();
        f_wr = 1'b0;
        check("f_head1", f_rdata, 32'h66);
        f_rd = 1'b1;
        cyc();
        f_rd = 1'b0;
        check("f_head2", f_rdata, 32'h77);
        check("f_count", f_count, 1);

        cyc(); cyc(); cyc();
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
